// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if
// Bundles the controller-to-PC command strobes and the PC/stack status
// returned to the controller. The clock and reset stay outside as plain ports.
//
// Signals:
//   en          global advance enable (0 = stall everything)
//   inc/skip    PC+1 / PC+2
//   rel         PC+offset (two's complement)
//   load        PC <= data_in
//   call/ret    push PC+1 and jump / pop into PC
//   clr_err     clears the sticky overflow/underflow flags
//   data_in     jump/call target
//   offset      relative branch offset
//   pc          current fetch address
//   sp          number of valid return-address entries
//   stack_full  sp == STACK_DEPTH
//   stack_empty sp == 0
//   overflow    sticky: call attempted while full
//   underflow   sticky: ret attempted while empty
interface pc_stack_unit_if #(
   parameter int ADDR_W      = 5,
   parameter int STACK_DEPTH = 4
);
   localparam int SP_W = $clog2(STACK_DEPTH + 1);

   logic              en;
   logic              inc;
   logic              skip;
   logic              rel;
   logic              load;
   logic              call;
   logic              ret;
   logic              clr_err;
   logic [ADDR_W-1:0] data_in;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] pc;
   logic [SP_W-1:0]   sp;
   logic              stack_full;
   logic              stack_empty;
   logic              overflow;
   logic              underflow;

   // Controller side: issues commands, observes PC and stack status.
   modport master (
      output en, inc, skip, rel, load, call, ret, clr_err, data_in, offset,
      input  pc, sp, stack_full, stack_empty, overflow, underflow
   );

   // PC unit side.
   modport slave (
      input  en, inc, skip, rel, load, call, ret, clr_err, data_in, offset,
      output pc, sp, stack_full, stack_empty, overflow, underflow
   );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
// Program counter with a hardware return-address stack. Executes one command
// per enabled cycle with fixed priority call > ret > load > rel > skip > inc.
// Stack overflow/underflow are reported through sticky flags so the
// controller can trap; a faulting call/ret is a NOP.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      pc_stack_unit_if slave modport (commands in, PC/stack status out)
module pc_stack_unit #(
   parameter int ADDR_W      = 5,
   parameter int STACK_DEPTH = 4,
   parameter int RESET_ADDR  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   pc_stack_unit_if.slave   bus
);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_ADDR);
   localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_next;
   logic [SP_W-1:0]   sp_q, sp_next;
   logic              ovf_q, ovf_next;
   logic              unf_q, unf_next;
   logic              push_en;
   logic              full;
   logic              empty;
   logic [IDX_W-1:0]  push_idx;
   logic [IDX_W-1:0]  pop_idx;
   logic [ADDR_W-1:0] ret_addr;

   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   assign full     = (sp_q == SP_FULL);
   assign empty    = (sp_q == '0);
   // Indices are only used when the stack is not full (push) or not empty
   // (pop), so truncating sp to the entry index never goes out of range.
   assign push_idx = IDX_W'(sp_q);
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
   assign ret_addr = pc_q + ADDR_W'(1);

   // Next-state selection. clr_err is applied first so a flag set by a
   // faulting call/ret in the same cycle overrides the clear.
   always_comb begin
      pc_next  = pc_q;
      sp_next  = sp_q;
      ovf_next = ovf_q;
      unf_next = unf_q;
      push_en  = 1'b0;
      if (bus.en) begin
         if (bus.clr_err) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
         end
         if (bus.call) begin
            if (full) begin
               ovf_next = 1'b1;
            end else begin
               push_en = 1'b1;
               sp_next = sp_q + SP_W'(1);
               pc_next = bus.data_in;
            end
         end else if (bus.ret) begin
            if (empty) begin
               unf_next = 1'b1;
            end else begin
               sp_next = sp_q - SP_W'(1);
               pc_next = stack_mem[pop_idx];
            end
         end else if (bus.load) begin
            pc_next = bus.data_in;
         end else if (bus.rel) begin
            pc_next = pc_q + bus.offset;
         end else if (bus.skip) begin
            pc_next = pc_q + ADDR_W'(2);
         end else if (bus.inc) begin
            pc_next = pc_q + ADDR_W'(1);
         end
      end
   end

   // Architectural state: PC, stack pointer and sticky fault flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q  <= RST_PC;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_next;
         sp_q  <= sp_next;
         ovf_q <= ovf_next;
         unf_q <= unf_next;
      end
   end

   // Return-address storage needs no reset: entries at or above sp are
   // never read.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[push_idx] <= ret_addr;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.sp          = sp_q;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit
// Directed self-checking bench for pc_stack_unit (ADDR_W=5, STACK_DEPTH=4).
// Each step drives a command, queues the expected PC/stack state and compares
// it after the following rising edge.
module tb_pc_stack_unit;
   localparam int ADDR_W      = 5;
   localparam int STACK_DEPTH = 4;
   localparam int SP_W        = $clog2(STACK_DEPTH + 1);

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_INC  = 6'b000001;
   localparam logic [5:0] C_SKIP = 6'b000010;
   localparam logic [5:0] C_REL  = 6'b000100;
   localparam logic [5:0] C_LOAD = 6'b001000;
   localparam logic [5:0] C_RET  = 6'b010000;
   localparam logic [5:0] C_CALL = 6'b100000;

   typedef struct {
      string             tag;
      logic [ADDR_W-1:0] pc;
      logic [SP_W-1:0]   sp;
      logic              ovf;
      logic              unf;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   exp_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   pc_stack_unit_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

   pc_stack_unit #(
      .ADDR_W(ADDR_W),
      .STACK_DEPTH(STACK_DEPTH),
      .RESET_ADDR(0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Puts one command on the bus.
   task automatic driveInputs(input logic en, input logic [5:0] cmd, input logic clr,
                              input logic [ADDR_W-1:0] din, input logic [ADDR_W-1:0] off);
      bus.en      = en;
      bus.call    = cmd[5];
      bus.ret     = cmd[4];
      bus.load    = cmd[3];
      bus.rel     = cmd[2];
      bus.skip    = cmd[1];
      bus.inc     = cmd[0];
      bus.clr_err = clr;
      bus.data_in = din;
      bus.offset  = off;
   endtask

   task automatic checkField(input string tag, input string name,
                             input logic [7:0] obs, input logic [7:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, expv);
      end
   endtask

   // Pops the oldest expectation and compares it against the DUT outputs.
   task automatic checkOutput();
      exp_t e;
      if (sb_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL scoreboard empty observed=0 expected=1");
      end else begin
         e = sb_q.pop_front();
         checkField(e.tag, "pc",    8'(bus.pc),          8'(e.pc));
         checkField(e.tag, "sp",    8'(bus.sp),          8'(e.sp));
         checkField(e.tag, "ovf",   8'(bus.overflow),    8'(e.ovf));
         checkField(e.tag, "unf",   8'(bus.underflow),   8'(e.unf));
         checkField(e.tag, "full",  8'(bus.stack_full),  8'(e.sp == SP_W'(STACK_DEPTH)));
         checkField(e.tag, "empty", 8'(bus.stack_empty), 8'(e.sp == SP_W'(0)));
      end
   endtask

   // Compares the current outputs without waiting for a clock edge.
   task automatic checkNow(input string tag, input logic [ADDR_W-1:0] e_pc,
                           input logic [SP_W-1:0] e_sp, input logic e_ovf, input logic e_unf);
      sb_q.push_back('{tag, e_pc, e_sp, e_ovf, e_unf});
      checkOutput();
   endtask

   // Drives one command, queues its expected result, clocks it and checks.
   task automatic applyStimulus(input string tag, input logic en, input logic [5:0] cmd,
                                input logic clr, input logic [ADDR_W-1:0] din,
                                input logic [ADDR_W-1:0] off, input logic [ADDR_W-1:0] e_pc,
                                input logic [SP_W-1:0] e_sp, input logic e_ovf, input logic e_unf);
      driveInputs(en, cmd, clr, din, off);
      sb_q.push_back('{tag, e_pc, e_sp, e_ovf, e_unf});
      @(posedge clk);
      #1;
      checkOutput();
      driveInputs(1'b1, C_NONE, 1'b0, '0, '0);
   endtask

   initial begin
      reset_n = 1'b0;
      driveInputs(1'b1, C_NONE, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      checkNow("reset", 5'd0, 3'd0, 1'b0, 1'b0);
      reset_n = 1'b1;

      // Asynchronous reset from a non-zero PC, then increment through the wrap.
      applyStimulus("load7", 1, C_LOAD, 0, 5'd7, 5'd0, 5'd7, 3'd0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      checkNow("async_rst", 5'd0, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         applyStimulus("inc", 1, C_INC, 0, 5'd0, 5'd0, 5'(i), 3'd0, 0, 0);
      end

      // Absolute and relative jumps, skip, wrap on relative branch.
      applyStimulus("load10",  1, C_LOAD, 0, 5'd10, 5'd0,      5'd10, 3'd0, 0, 0);
      applyStimulus("load20",  1, C_LOAD, 0, 5'd20, 5'd0,      5'd20, 3'd0, 0, 0);
      applyStimulus("rel_m3",  1, C_REL,  0, 5'd0,  5'b11101,  5'd17, 3'd0, 0, 0);
      applyStimulus("skip",    1, C_SKIP, 0, 5'd0,  5'd0,      5'd19, 3'd0, 0, 0);
      applyStimulus("rel_p15", 1, C_REL,  0, 5'd0,  5'd15,     5'd2,  3'd0, 0, 0);

      // Nested call/return.
      applyStimulus("load3",   1, C_LOAD, 0, 5'd3,  5'd0, 5'd3,  3'd0, 0, 0);
      applyStimulus("call8",   1, C_CALL, 0, 5'd8,  5'd0, 5'd8,  3'd1, 0, 0);
      applyStimulus("call16",  1, C_CALL, 0, 5'd16, 5'd0, 5'd16, 3'd2, 0, 0);
      applyStimulus("ret_a",   1, C_RET,  0, 5'd0,  5'd0, 5'd9,  3'd1, 0, 0);
      applyStimulus("ret_b",   1, C_RET,  0, 5'd0,  5'd0, 5'd4,  3'd0, 0, 0);

      // Fill the stack, overflow, clear, then unwind in LIFO order.
      applyStimulus("fill1",   1, C_CALL, 0, 5'd1, 5'd0, 5'd1, 3'd1, 0, 0);
      applyStimulus("fill2",   1, C_CALL, 0, 5'd2, 5'd0, 5'd2, 3'd2, 0, 0);
      applyStimulus("fill3",   1, C_CALL, 0, 5'd3, 5'd0, 5'd3, 3'd3, 0, 0);
      applyStimulus("fill4",   1, C_CALL, 0, 5'd4, 5'd0, 5'd4, 3'd4, 0, 0);
      applyStimulus("ovf",     1, C_CALL | C_INC, 0, 5'd5, 5'd0, 5'd4, 3'd4, 1, 0);
      applyStimulus("ovf_clr_set", 1, C_CALL, 1, 5'd5, 5'd0, 5'd4, 3'd4, 1, 0);
      applyStimulus("ovf_clr", 1, C_NONE, 1, 5'd0, 5'd0, 5'd4, 3'd4, 0, 0);
      applyStimulus("pop4",    1, C_RET,  0, 5'd0, 5'd0, 5'd4, 3'd3, 0, 0);
      applyStimulus("pop3",    1, C_RET,  0, 5'd0, 5'd0, 5'd3, 3'd2, 0, 0);
      applyStimulus("pop2",    1, C_RET,  0, 5'd0, 5'd0, 5'd2, 3'd1, 0, 0);
      applyStimulus("pop1",    1, C_RET,  0, 5'd0, 5'd0, 5'd5, 3'd0, 0, 0);

      // Underflow without fall-through, priority, stall behaviour.
      applyStimulus("unf",       1, C_RET | C_INC, 0, 5'd0, 5'd0, 5'd5, 3'd0, 0, 1);
      applyStimulus("stall_clr", 0, C_NONE, 1, 5'd0, 5'd0, 5'd5, 3'd0, 0, 1);
      applyStimulus("prio",      1, C_CALL | C_LOAD | C_INC, 0, 5'd12, 5'd0, 5'd12, 3'd1, 0, 1);
      applyStimulus("unf_clr",   1, C_NONE, 1, 5'd0, 5'd0, 5'd12, 3'd1, 0, 0);
      applyStimulus("stall_call", 0, C_CALL, 0, 5'd20, 5'd0, 5'd12, 3'd1, 0, 0);

      // Wrap boundaries: call and skip from the top address.
      applyStimulus("load31a",  1, C_LOAD, 0, 5'd31, 5'd0, 5'd31, 3'd1, 0, 0);
      applyStimulus("call_max", 1, C_CALL, 0, 5'd0,  5'd0, 5'd0,  3'd2, 0, 0);
      applyStimulus("ret_max",  1, C_RET,  0, 5'd0,  5'd0, 5'd0,  3'd1, 0, 0);
      applyStimulus("ret_prio", 1, C_RET,  0, 5'd0,  5'd0, 5'd6,  3'd0, 0, 0);
      applyStimulus("load31b",  1, C_LOAD, 0, 5'd31, 5'd0, 5'd31, 3'd0, 0, 0);
      applyStimulus("skip_max", 1, C_SKIP, 0, 5'd0,  5'd0, 5'd1,  3'd0, 0, 0);
      applyStimulus("unf2",     1, C_RET,  0, 5'd0,  5'd0, 5'd1,  3'd0, 0, 1);

      // Reset asserted while a call is pending, then the call after release.
      driveInputs(1'b1, C_CALL, 1'b0, 5'd9, 5'd0);
      #2;
      reset_n = 1'b0;
      #1;
      checkNow("rst_mid_call", 5'd0, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkNow("rst_held", 5'd0, 3'd0, 1'b0, 1'b0);
      reset_n = 1'b1;
      applyStimulus("call_after_rst", 1, C_CALL, 0, 5'd9, 5'd0, 5'd9, 3'd1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
